// File: rtl/dac_wave_gen.sv
// DDS waveform generator for the 14-bit parallel DAC: saw/square/triangle from a phase
// accumulator, shift attenuation + offset, settings shadowed until phase wrap. Optional sine: DAC_WAVE_SINE_EN.
`timescale 1ns/1ps
module dac_wave_gen #(
  parameter int PHASE_W = 24,
  parameter int CLK_DIV = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_tuning_word,
  input  logic [1:0]         i_wave_sel,
  input  logic [3:0]         i_amp_shift,
  input  logic [13:0]        i_offset,
  output logic               o_load_ack,
  output logic               o_pending,
  output logic               o_wrap,
  output logic [13:0]        o_dac_data,
  output logic               o_dac_wrt
);
`ifdef DAC_WAVE_SINE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;
  typedef struct packed {
    logic [PHASE_W-1:0] tw;
    logic [1:0]         ws;
    logic [3:0]         amp;
    logic [13:0]        off;
  } cfg_t;

  state_t             r_state, w_state_n;
  cfg_t               r_act, r_sh, w_in, w_new;
  logic               w_apply, w_capture, w_use_in, r_ack;
  logic [7:0]         r_div;
  logic [PHASE_W-1:0] r_acc, w_tw_use;
  logic               r_wrap, w_tick;
  logic [LAT:0]       r_vld;
  logic [13:0]        w_p, w_p_src, w_tri, w_raw, r_raw, r_dac;
  logic [3:0]         w_shift;
  logic [14:0]        w_sum;

  assign w_in  = '{tw: i_tuning_word, ws: i_wave_sel, amp: i_amp_shift, off: i_offset};
  assign w_new = w_use_in ? w_in : r_sh;
  // The value being applied this cycle steers the very next tick, so a new step starts cleanly at the wrap.
  assign w_tw_use = w_apply ? w_new.tw : r_act.tw;

  always_comb begin
    w_state_n = r_state;
    w_apply   = 1'b0;
    w_capture = 1'b0;
    w_use_in  = 1'b0;
    case (r_state)
      S_IDLE, S_RUN: begin
        w_state_n = i_enable ? S_RUN : S_IDLE;
        if (i_load) begin
          if (r_state == S_IDLE || !i_enable || r_wrap) begin
            w_apply  = 1'b1;
            w_use_in = 1'b1;
          end else begin
            w_capture = 1'b1;
            w_state_n = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (r_wrap || !i_enable) begin
          w_apply   = 1'b1;
          w_use_in  = i_load;
          w_state_n = i_enable ? S_RUN : S_IDLE;
        end else if (i_load) begin
          w_capture = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_act   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_n;
      r_ack   <= w_apply;
      if (w_capture) r_sh  <= w_in;
      if (w_apply)   r_act <= w_new;
    end
  end

  assign w_tick = i_enable && (r_div == DIV_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_div  <= '0;
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (!i_enable) begin
      r_div  <= '0;
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (w_tick) begin
      r_div           <= '0;
      {r_wrap, r_acc} <= {1'b0, r_acc} + {1'b0, w_tw_use};
    end else begin
      r_div  <= r_div + 8'd1;
      r_wrap <= 1'b0;
    end
  end

  // vld[0] marks an acc update; dropping enable flushes in-flight samples so no late strobe appears.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_vld <= '0;
    else         r_vld <= i_enable ? {r_vld[LAT-1:0], w_tick} : '0;
  end

  assign w_p = r_acc[PHASE_W-1 -: 14];

`ifdef DAC_WAVE_SINE_EN
  function automatic logic [12:0] sin_q(input logic [5:0] idx);
    case (idx)
      6'd0:  sin_q = 13'd101;  6'd1:  sin_q = 13'd301;  6'd2:  sin_q = 13'd502;  6'd3:  sin_q = 13'd703;
      6'd4:  sin_q = 13'd903;  6'd5:  sin_q = 13'd1102; 6'd6:  sin_q = 13'd1301; 6'd7:  sin_q = 13'd1499;
      6'd8:  sin_q = 13'd1696; 6'd9:  sin_q = 13'd1893; 6'd10: sin_q = 13'd2088; 6'd11: sin_q = 13'd2281;
      6'd12: sin_q = 13'd2474; 6'd13: sin_q = 13'd2665; 6'd14: sin_q = 13'd2854; 6'd15: sin_q = 13'd3041;
      6'd16: sin_q = 13'd3227; 6'd17: sin_q = 13'd3411; 6'd18: sin_q = 13'd3593; 6'd19: sin_q = 13'd3772;
      6'd20: sin_q = 13'd3950; 6'd21: sin_q = 13'd4124; 6'd22: sin_q = 13'd4297; 6'd23: sin_q = 13'd4467;
      6'd24: sin_q = 13'd4634; 6'd25: sin_q = 13'd4798; 6'd26: sin_q = 13'd4960; 6'd27: sin_q = 13'd5118;
      6'd28: sin_q = 13'd5274; 6'd29: sin_q = 13'd5426; 6'd30: sin_q = 13'd5575; 6'd31: sin_q = 13'd5720;
      6'd32: sin_q = 13'd5863; 6'd33: sin_q = 13'd6001; 6'd34: sin_q = 13'd6136; 6'd35: sin_q = 13'd6268;
      6'd36: sin_q = 13'd6395; 6'd37: sin_q = 13'd6519; 6'd38: sin_q = 13'd6638; 6'd39: sin_q = 13'd6754;
      6'd40: sin_q = 13'd6866; 6'd41: sin_q = 13'd6973; 6'd42: sin_q = 13'd7077; 6'd43: sin_q = 13'd7176;
      6'd44: sin_q = 13'd7271; 6'd45: sin_q = 13'd7361; 6'd46: sin_q = 13'd7447; 6'd47: sin_q = 13'd7528;
      6'd48: sin_q = 13'd7605; 6'd49: sin_q = 13'd7678; 6'd50: sin_q = 13'd7746; 6'd51: sin_q = 13'd7809;
      6'd52: sin_q = 13'd7867; 6'd53: sin_q = 13'd7921; 6'd54: sin_q = 13'd7969; 6'd55: sin_q = 13'd8013;
      6'd56: sin_q = 13'd8053; 6'd57: sin_q = 13'd8087; 6'd58: sin_q = 13'd8117; 6'd59: sin_q = 13'd8141;
      6'd60: sin_q = 13'd8161; 6'd61: sin_q = 13'd8176; 6'd62: sin_q = 13'd8185; default: sin_q = 13'd8190;
    endcase
  endfunction

  logic [13:0] r_p, w_sine;
  logic [5:0]  w_q_idx;
  logic [12:0] w_q;

  // Extra phase register keeps the ROM lookup off the accumulator path; all waves share the latency.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_p <= '0;
    else         r_p <= w_p;
  end
  assign w_p_src = r_p;
  assign w_q_idx = w_p_src[12] ? ~w_p_src[11:6] : w_p_src[11:6];
  assign w_q     = sin_q(w_q_idx);
  assign w_sine  = w_p_src[13] ? (14'h2000 - {1'b0, w_q}) : (14'h2000 + {1'b0, w_q});
`else
  assign w_p_src = w_p;
`endif

  assign w_tri = {w_p_src[12:0] ^ {13{w_p_src[13]}}, 1'b0};

  always_comb begin
    w_raw = w_tri;
    case (r_act.ws)
      2'd0:    w_raw = w_p_src;
      2'd1:    w_raw = w_p_src[13] ? 14'h3FFF : 14'h0000;
`ifdef DAC_WAVE_SINE_EN
      2'd3:    w_raw = w_sine;
`endif
      default: w_raw = w_tri;
    endcase
  end

  assign w_shift = (r_act.amp > 4'd13) ? 4'd13 : r_act.amp;
  assign w_sum   = {1'b0, r_raw >> w_shift} + {1'b0, r_act.off};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_raw <= '0;
      r_dac <= '0;
    end else begin
      r_raw <= w_raw;
      if (i_enable && r_vld[LAT-1]) r_dac <= w_sum[14] ? 14'h3FFF : w_sum[13:0];
    end
  end

  assign o_load_ack = r_ack;
  assign o_pending  = (r_state == S_PEND);
  assign o_wrap     = r_wrap;
  assign o_dac_data = r_dac;
  assign o_dac_wrt  = r_vld[LAT];

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen (default build): one instance at CLK_DIV=1, one at CLK_DIV=4.
`timescale 1ns/1ps
module tb_dac_wave_gen;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, ld = 1'b0;
  logic [23:0] tw = '0;
  logic [1:0]  ws = '0;
  logic [3:0]  amp = '0;
  logic [13:0] off = '0;
  logic        a1, p1, w1, r1, a4, p4, w4, r4;
  logic [13:0] d1, d4;
  int          errs = 0, checks = 0, cyc = 0, wrt_cnt = 0;

  always #5 clk = ~clk;

  dac_wave_gen #(.PHASE_W(24), .CLK_DIV(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_load(ld), .i_tuning_word(tw),
    .i_wave_sel(ws), .i_amp_shift(amp), .i_offset(off), .o_load_ack(a1), .o_pending(p1),
    .o_wrap(w1), .o_dac_data(d1), .o_dac_wrt(r1));

  dac_wave_gen #(.PHASE_W(24), .CLK_DIV(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_load(ld), .i_tuning_word(tw),
    .i_wave_sel(ws), .i_amp_shift(amp), .i_offset(off), .o_load_ack(a4), .o_pending(p4),
    .o_wrap(w4), .o_dac_data(d4), .o_dac_wrt(r4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    wrt_cnt += int'(r1);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Stop, load new settings while idle, then re-enable; cycle 1 is the first tick of d1.
  task automatic restart(input logic [23:0] t, input logic [1:0] w, input logic [3:0] a, input logic [13:0] o);
    en = 1'b0;
    step();
    ld = 1'b1; tw = t; ws = w; amp = a; off = o;
    step();
    chk("idle_load_ack", a1, 1);
    ld = 1'b0;
    en = 1'b1;
    cyc = 0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_dac", d1, 0);
    chk("rst_wrt", r1, 0);
    chk("rst_wrap", w1, 0);
    chk("rst_ack", a1, 0);
    chk("rst_pend", p1, 0);
    rst = 1'b0;
    step();

    // saw, step 0x100 per sample
    restart(24'h040000, 2'd0, 4'd0, 14'h0);
    run_to(2);  chk("saw_wrt_lat", r1, 0);
    wrt_cnt = 0;
    run_to(3);  chk("saw_first", d1, 32'h100); chk("saw_wrt", r1, 1);
    run_to(4);  chk("saw_second", d1, 32'h200);
    run_to(6);  chk("div4_first", d4, 32'h100); chk("div4_wrt", r4, 1);
    run_to(7);  chk("div4_wrt_gap", r4, 0);
    run_to(63); chk("saw_nowrap", w1, 0);
    run_to(64); chk("saw_wrap", w1, 1);
    run_to(65); chk("saw_top", d1, 32'h3F00); chk("saw_wrap_pulse", w1, 0);
    run_to(66); chk("saw_rollover", d1, 0);
    run_to(128); chk("saw_wrap2", w1, 1);
    run_to(130); chk("saw_wrt_count", wrt_cnt, 128);

    // square with offset: high half saturates
    restart(24'h040000, 2'd1, 4'd0, 14'h0100);
    run_to(3);  chk("sq_low", d1, 32'h100);
    run_to(34); chk("sq_high_sat", d1, 32'h3FFF);
    run_to(65); chk("sq_high_end", d1, 32'h3FFF);
    run_to(66); chk("sq_low_again", d1, 32'h100);

    // triangle, shift 1
    restart(24'h040000, 2'd2, 4'd1, 14'h0);
    run_to(3);  chk("tri_rise", d1, 32'h100);
    run_to(33); chk("tri_near_peak", d1, 32'h1F00);
    run_to(34); chk("tri_peak", d1, 32'h1FFF);
    run_to(35); chk("tri_fall", d1, 32'h1EFF);
    run_to(66); chk("tri_trough", d1, 0);

    // shift 15 clamps to 13: only the top raw bit survives
    restart(24'h040000, 2'd2, 4'd15, 14'h0);
    run_to(10); chk("tri_sh15_low", d1, 0);
    run_to(34); chk("tri_sh15_peak", d1, 1);

    // wave_sel 3 falls back to triangle without the sine option
    restart(24'h040000, 2'd3, 4'd0, 14'h0);
    run_to(35); chk("sel3_tri", d1, 32'h3DFE);

    // shadowed load: last one wins, applied at wrap
    restart(24'h040000, 2'd0, 4'd0, 14'h0);
    run_to(10);
    ld = 1'b1; tw = 24'h080000;
    step();
    ld = 1'b0;
    chk("pend_set", p1, 1); chk("pend_noack", a1, 0);
    run_to(20);
    ld = 1'b1; tw = 24'h100000;
    step();
    ld = 1'b0;
    chk("pend_overwrite", p1, 1); chk("pend_overwrite_noack", a1, 0);
    run_to(40); chk("pend_old_step", d1, 32'h2600);
    run_to(64); chk("pend_wrap", w1, 1); chk("pend_before_ack", p1, 1); chk("ack_not_yet", a1, 0);
    run_to(65); chk("wrap_ack", a1, 1); chk("pend_clear", p1, 0); chk("pend_last_old", d1, 32'h3F00);
    run_to(66); chk("ack_single", a1, 0); chk("new_period_zero", d1, 0);
    run_to(67); chk("new_step1", d1, 32'h400);
    run_to(68); chk("new_step2", d1, 32'h800);

    // disable: data holds, no strobe, idle load acks next clock
    en = 1'b0; tw = 24'h0;
    step();
    chk("dis_hold", d1, 32'h800); chk("dis_nowrt", r1, 0); chk("dis_pend", p1, 0);
    ld = 1'b1; tw = 24'h000123;
    step();
    ld = 1'b0;
    chk("dis_load_ack", a1, 1); chk("dis_load_nowrt", r1, 0); chk("dis_load_hold", d1, 32'h800);
    step();
    chk("dis_ack_pulse", a1, 0); chk("dis_hold2", d1, 32'h800); chk("dis_nowrap", w1, 0);

    // dropping enable forces a pending load through
    restart(24'h040000, 2'd0, 4'd0, 14'h0);
    run_to(5);
    ld = 1'b1; tw = 24'h0;
    step();
    ld = 1'b0;
    chk("force_pend", p1, 1);
    en = 1'b0;
    step();
    chk("force_ack", a1, 1); chk("force_pend_clr", p1, 0);

    // asynchronous reset mid-run on the divided instance
    restart(24'h040000, 2'd0, 4'd0, 14'h0);
    run_to(10); chk("div4_run", d4, 32'h200); chk("div4_run_wrt", r4, 1);
    ld = 1'b1; tw = 24'h080000;
    step();
    ld = 1'b0;
    chk("div4_pend", p4, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dac4", d4, 0); chk("arst_pend4", p4, 0); chk("arst_ack4", a4, 0); chk("arst_dac1", d1, 0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("arst_no_ack", a4, 0); chk("arst_no_pend", p4, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
